// File: rtl/mem_resp_pkg.sv
// Shared types and helpers for the mem_responder memory target.
// Optional feature macro used by the top: MEM_RESP_ALIGN_CHECK_EN.
package mem_resp_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    // True when the word index addresses an existing array entry.
    function automatic logic idx_in_range(input logic [ADDR_W-3:0] widx,
                                          input int unsigned depth);
        return ({2'b00, widx} < depth);
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Load/store request bus between the core (master) and the memory responder (slave).
interface mem_responder_if;
    import mem_resp_pkg::*;

    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;
    logic              err;

    modport master (
        output req,
        output we,
        output addr,
        output wdata,
        input  ack,
        input  rdata,
        input  err
    );

    modport slave (
        input  req,
        input  we,
        input  addr,
        input  wdata,
        output ack,
        output rdata,
        output err
    );

endinterface

// File: rtl/mem_resp_array.sv
// DEPTH x DATA_W storage with one synchronous read/write port.
// Contents are never reset; rdata_o changes only on an enabled read.
module mem_resp_array
    import mem_resp_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned IdxW  = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [IdxW-1:0]   idx_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[idx_i] <= wdata_i;
            end else begin
                rdata_q <= mem_q[idx_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Word-addressed memory responder with programmable wait states and error flag.
// Define MEM_RESP_ALIGN_CHECK_EN to flag addr[1:0] != 0 as an error.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input logic            clk_i,
    input logic            rst_ni,
    mem_responder_if.slave bus
);

    localparam int unsigned IdxW = $clog2(DEPTH);

    state_e            state_q;
    logic [3:0]        cnt_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              ack_q;
    logic              err_q;
    logic              rd_valid_q;

    logic              acc_go;
    logic              acc_we;
    logic              acc_err;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic              arr_en;
    logic [DATA_W-1:0] arr_rdata;

    // The array access happens on the edge that enters StResp. With zero wait
    // states that is the acceptance edge, so the live bus feeds the port.
    always_comb begin
        acc_go    = 1'b0;
        acc_we    = we_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        unique case (state_q)
            StIdle: begin
                acc_we    = bus.we;
                acc_addr  = bus.addr;
                acc_wdata = bus.wdata;
                acc_go    = bus.req && (WAIT_CYCLES == 0);
            end
            StWait:  acc_go = (cnt_q == 4'd1);
            default: acc_go = 1'b0;
        endcase
    end

    always_comb begin
        acc_err = !idx_in_range(acc_addr[ADDR_W-1:2], DEPTH);
`ifdef MEM_RESP_ALIGN_CHECK_EN
        acc_err = acc_err || (acc_addr[1:0] != 2'b00);
`endif
    end

    // Held off during reset so an abandoned write never reaches the array.
    assign arr_en = acc_go && !acc_err && rst_ni;

    mem_resp_array #(
        .DEPTH (DEPTH),
        .IdxW  (IdxW)
    ) u_array (
        .clk_i   (clk_i),
        .en_i    (arr_en),
        .we_i    (acc_we),
        .idx_i   (acc_addr[IdxW+1:2]),
        .wdata_i (acc_wdata),
        .rdata_o (arr_rdata)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.req) begin
                        we_q    <= bus.we;
                        addr_q  <= bus.addr;
                        wdata_q <= bus.wdata;
                        cnt_q   <= 4'(WAIT_CYCLES);
                        state_q <= (WAIT_CYCLES > 0) ? StWait : StResp;
                    end
                end
                StWait: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q <= StResp;
                    end
                end
                StResp:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
            if (acc_go) begin
                ack_q <= 1'b1;
                err_q <= acc_err;
                // A failed read shows zero; a write leaves the visible rdata alone.
                if (!acc_we) begin
                    rd_valid_q <= !acc_err;
                end
            end
        end
    end

    assign bus.ack   = ack_q;
    assign bus.err   = err_q;
    assign bus.rdata = rd_valid_q ? arr_rdata : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Directed scoreboard bench for mem_responder: a 2-wait-state DUT and a zero-wait DUT.
// Honours MEM_RESP_ALIGN_CHECK_EN when predicting error responses.
module tb_mem_responder;

    localparam int unsigned DEPTH  = 64;
    localparam int unsigned WAIT_A = 2;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic clk;
    logic rst_n;

    mem_responder_if bus_a ();
    mem_responder_if bus_b ();

    mem_responder #(
        .DEPTH       (DEPTH),
        .WAIT_CYCLES (WAIT_A)
    ) dut_a (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus_a)
    );

    mem_responder #(
        .DEPTH       (DEPTH),
        .WAIT_CYCLES (0)
    ) dut_b (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus_b)
    );

    int          tests = 0;
    int          fails = 0;
    exp_t        sb[$];
    logic [31:0] model [DEPTH];
    logic [31:0] last_rdata;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic predict(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
        exp_t e;
        logic bad;
        bad = (addr[31:2] >= DEPTH);
`ifdef MEM_RESP_ALIGN_CHECK_EN
        bad = bad || (addr[1:0] != 2'b00);
`endif
        if (we) begin
            if (!bad) model[addr[7:2]] = wdata;
        end else begin
            last_rdata = bad ? 32'h0 : model[addr[7:2]];
        end
        e.rdata = last_rdata;
        e.err   = bad;
        sb.push_back(e);
    endtask

    // Called at a negedge with dut_a idle; returns at a negedge with dut_a idle.
    task automatic issue(input string tag, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata);
        int   edges;
        bit   seen;
        exp_t e;
        predict(we, addr, wdata);
        bus_a.req   = 1'b1;
        bus_a.we    = we;
        bus_a.addr  = addr;
        bus_a.wdata = wdata;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        // Scramble the bus after acceptance; the response must use latched values.
        bus_a.req   = 1'b0;
        bus_a.we    = ~we;
        bus_a.addr  = $urandom;
        bus_a.wdata = $urandom;
        seen = bus_a.ack;
        while (!seen && edges < 20) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            seen = bus_a.ack;
        end
        e = sb.pop_front();
        check({tag, "_latency"}, edges, WAIT_A + 1);
        if (seen) begin
            check({tag, "_rdata"}, bus_a.rdata, e.rdata);
            check({tag, "_err"}, bus_a.err, e.err);
        end
        @(negedge clk);
        check({tag, "_ack_pulse"}, bus_a.ack, 1'b0);
    endtask

    initial begin
        int acks;
        logic exp_align_err;
        rst_n       = 1'b0;
        bus_a.req   = 1'b0;
        bus_a.we    = 1'b0;
        bus_a.addr  = '0;
        bus_a.wdata = '0;
        bus_b.req   = 1'b0;
        bus_b.we    = 1'b0;
        bus_b.addr  = '0;
        bus_b.wdata = '0;
        last_rdata  = 32'h0;
        #12;
        check("rst_a_ack", bus_a.ack, 1'b0);
        check("rst_a_err", bus_a.err, 1'b0);
        check("rst_a_rdata", bus_a.rdata, 32'h0);
        check("rst_b_ack", bus_b.ack, 1'b0);
        check("rst_b_rdata", bus_b.rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic write then read with two wait states.
        issue("wr10", 1'b1, 32'h10, 32'hCAFE_0001);
        issue("rd10", 1'b0, 32'h10, 32'h0);

        // Out-of-range accesses.
        issue("wr00", 1'b1, 32'h00, 32'hA5A5_0000);
        issue("rd100", 1'b0, 32'h100, 32'h0);
        issue("wr100", 1'b1, 32'h100, 32'h0BAD_0BAD);
        issue("rd00", 1'b0, 32'h00, 32'h0);

        // Misaligned write: dropped only with the alignment check enabled.
        issue("wr12", 1'b1, 32'h12, 32'h1234_5678);
        issue("rd10b", 1'b0, 32'h10, 32'h0);
`ifdef MEM_RESP_ALIGN_CHECK_EN
        exp_align_err = 1'b1;
`else
        exp_align_err = 1'b0;
`endif
        check("align_model_word4", model[4],
              exp_align_err ? 32'hCAFE_0001 : 32'h1234_5678);

        // Zero-wait DUT with req held high across write and read.
        bus_b.req   = 1'b1;
        bus_b.we    = 1'b1;
        bus_b.addr  = 32'h04;
        bus_b.wdata = 32'h5A5A_0404;
        @(posedge clk);
        @(negedge clk);
        check("w0_wr_ack", bus_b.ack, 1'b1);
        check("w0_wr_err", bus_b.err, 1'b0);
        check("w0_wr_rdata", bus_b.rdata, 32'h0);
        bus_b.we = 1'b0;
        @(negedge clk);
        check("w0_gap_ack", bus_b.ack, 1'b0);
        @(negedge clk);
        check("w0_rd_ack", bus_b.ack, 1'b1);
        check("w0_rd_rdata", bus_b.rdata, 32'h5A5A_0404);
        check("w0_rd_err", bus_b.err, 1'b0);
        bus_b.req = 1'b0;
        @(negedge clk);
        check("w0_idle_ack", bus_b.ack, 1'b0);
        check("w0_hold_rdata", bus_b.rdata, 32'h5A5A_0404);

        // Reset in the middle of a write's wait states.
        issue("wr20", 1'b1, 32'h20, 32'h1111_1111);
        issue("rd20", 1'b0, 32'h20, 32'h0);
        bus_a.req   = 1'b1;
        bus_a.we    = 1'b1;
        bus_a.addr  = 32'h20;
        bus_a.wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        bus_a.req = 1'b0;
        check("mid_wait_ack", bus_a.ack, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_rdata", bus_a.rdata, 32'h0);
        check("async_rst_err", bus_a.err, 1'b0);
        last_rdata = 32'h0;
        acks = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus_a.ack) acks++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus_a.ack) acks++;
        end
        check("rst_no_ack", acks, 0);
        check("post_rst_rdata", bus_a.rdata, 32'h0);
        issue("rd20_after_rst", 1'b0, 32'h20, 32'h0);

        check("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
